// File: rtl/ngs_boot_avm_pkg.sv
// Shared types for the boot-path Avalon-MM sequencer: op/status codes, FSM states
// and the poll compare helper.
package ngs_boot_avm_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_TIMEOUT = 2'b01,
        ST_BAD_OP  = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ISSUE     = 2'b01,
        S_WAIT_DATA = 2'b10,
        S_RESPOND   = 2'b11
    } state_e;

    // Latched command fields that are independent of the address width.
    typedef struct packed {
        op_e               op;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic [BE_W-1:0]   be;
    } cmd_fields_t;

    function automatic logic poll_match(input logic [DATA_W-1:0] rdata,
                                        input logic [DATA_W-1:0] cmp,
                                        input logic [DATA_W-1:0] mask);
        return ((rdata ^ cmp) & mask) == '0;
    endfunction

endpackage

// File: rtl/ngs_boot_avm_counter.sv
// Saturating up-counter with synchronous clear; flags when it sits at all-ones.
module ngs_boot_avm_counter #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic at_max_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != MAX)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign at_max_o = (count_q == MAX);

endmodule

// File: rtl/ngs_boot_avm_sequencer.sv
// Single-outstanding Avalon-MM initiator executing WRITE/READ/POLL commands from
// the boot host path, with a read watchdog and a bounded poll-attempt count.
module ngs_boot_avm_sequencer
    import ngs_boot_avm_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned TIMEOUT_W = 10,
    parameter int unsigned POLL_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_address_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    input  logic [DATA_W-1:0] cmd_mask_i,
    input  logic [BE_W-1:0]   cmd_byteenable_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [1:0]        rsp_status_o,
    output logic [ADDR_W-1:0] avm_address_o,
    output logic              avm_read_o,
    output logic              avm_write_o,
    output logic [DATA_W-1:0] avm_writedata_o,
    output logic [BE_W-1:0]   avm_byteenable_o,
    input  logic              avm_waitrequest_i,
    input  logic [DATA_W-1:0] avm_readdata_i,
    input  logic              avm_readdatavalid_i
);

    state_e            state_q, state_d;
    cmd_fields_t       cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    status_e           rsp_status_q, rsp_status_d;

    logic wd_clr, wd_inc, wd_at_max;
    logic poll_clr, poll_inc, poll_at_max;
    logic poll_hit;
    op_e  cmd_op;

    assign cmd_op   = op_e'(cmd_op_i);
    assign poll_hit = poll_match(avm_readdata_i, cmd_q.data, cmd_q.mask);

    ngs_boot_avm_counter #(.W(TIMEOUT_W)) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (wd_clr),
        .inc_i    (wd_inc),
        .at_max_o (wd_at_max)
    );

    ngs_boot_avm_counter #(.W(POLL_W)) u_poll_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (poll_clr),
        .inc_i    (poll_inc),
        .at_max_o (poll_at_max)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = (cmd_op == OP_RSVD) ? S_RESPOND : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!avm_waitrequest_i) begin
                    state_d = (cmd_q.op == OP_WRITE) ? S_RESPOND : S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (avm_readdatavalid_i) begin
                    if ((cmd_q.op == OP_READ) || poll_hit || poll_at_max) begin
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (wd_at_max) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Both counters advance when a read is accepted by the fabric, so the
    // watchdog measures cycles since acceptance and the poll counter counts reads.
    always_comb begin
        cmd_d        = cmd_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        wd_clr       = 1'b0;
        wd_inc       = 1'b0;
        poll_clr     = 1'b0;
        poll_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    cmd_d.op   = cmd_op;
                    cmd_d.data = cmd_data_i;
                    cmd_d.mask = cmd_mask_i;
                    cmd_d.be   = cmd_byteenable_i;
                    addr_d     = cmd_address_i;
                    wd_clr     = 1'b1;
                    poll_clr   = 1'b1;
                    if (cmd_op == OP_RSVD) begin
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_status_d = ST_BAD_OP;
                    end else begin
                        wr_d = (cmd_op == OP_WRITE);
                        rd_d = (cmd_op != OP_WRITE);
                    end
                end
            end
            S_ISSUE: begin
                if (!avm_waitrequest_i) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (cmd_q.op == OP_WRITE) begin
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_status_d = ST_OK;
                    end else begin
                        wd_inc   = 1'b1;
                        poll_inc = 1'b1;
                    end
                end
            end
            S_WAIT_DATA: begin
                if (avm_readdatavalid_i) begin
                    if ((cmd_q.op == OP_READ) || poll_hit) begin
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = avm_readdata_i;
                        rsp_status_d = ST_OK;
                    end else if (poll_at_max) begin
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = avm_readdata_i;
                        rsp_status_d = ST_TIMEOUT;
                    end else begin
                        wd_clr = 1'b1;
                        rd_d   = 1'b1;
                    end
                end else if (wd_at_max) begin
                    rsp_valid_d  = 1'b1;
                    rsp_data_d   = '0;
                    rsp_status_d = ST_TIMEOUT;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            S_RESPOND: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                rd_d        = 1'b0;
                wr_d        = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q        <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            cmd_q        <= cmd_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign cmd_ready_o      = (state_q == S_IDLE);
    assign rsp_valid_o      = rsp_valid_q;
    assign rsp_data_o       = rsp_data_q;
    assign rsp_status_o     = rsp_status_q;
    assign avm_address_o    = addr_q;
    assign avm_read_o       = rd_q;
    assign avm_write_o      = wr_q;
    assign avm_writedata_o  = cmd_q.data;
    assign avm_byteenable_o = cmd_q.be;

endmodule

// File: tb/tb_ngs_boot_avm_sequencer.sv
// Directed bench for ngs_boot_avm_sequencer (TIMEOUT_W=4, POLL_W=2).
module tb_ngs_boot_avm_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_address;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_be;
    logic        waitreq;
    logic [31:0] rdata;
    logic        rdv;

    int n_cmp  = 0;
    int n_fail = 0;
    int reads_seen  = 0;
    int writes_seen = 0;
    int r0;
    int w0;

    always #5 clk = ~clk;

    ngs_boot_avm_sequencer #(
        .ADDR_W    (32),
        .TIMEOUT_W (4),
        .POLL_W    (2)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_op_i            (cmd_op),
        .cmd_address_i       (cmd_address),
        .cmd_data_i          (cmd_data),
        .cmd_mask_i          (cmd_mask),
        .cmd_byteenable_i    (cmd_be),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_data_o          (rsp_data),
        .rsp_status_o        (rsp_status),
        .avm_address_o       (avm_address),
        .avm_read_o          (avm_read),
        .avm_write_o         (avm_write),
        .avm_writedata_o     (avm_writedata),
        .avm_byteenable_o    (avm_be),
        .avm_waitrequest_i   (waitreq),
        .avm_readdata_i      (rdata),
        .avm_readdatavalid_i (rdv)
    );

    // Count bus transfers actually accepted by the fabric.
    always @(posedge clk) begin
        if (avm_read && !waitreq)  reads_seen  <= reads_seen + 1;
        if (avm_write && !waitreq) writes_seen <= writes_seen + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] mask);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_address = addr;
        cmd_data    = data;
        cmd_mask    = mask;
        cmd_be      = 4'hF;
        tick();
        cmd_valid   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_address = '0;
        cmd_data    = '0;
        cmd_mask    = '0;
        cmd_be      = '0;
        rsp_ready   = 1'b1;
        waitreq     = 1'b0;
        rdata       = '0;
        rdv         = 1'b0;
        tick();
        tick();
        chk("rst_read",      32'(avm_read), 32'd0);
        chk("rst_write",     32'(avm_write), 32'd0);
        chk("rst_addr",      avm_address, 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  rsp_data, 32'd0);
        chk("rst_rsp_stat",  32'(rsp_status), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        reset_n = 1'b1;
        tick();

        // WRITE, no waitrequest
        w0 = writes_seen;
        chk("w_ready_pre", 32'(cmd_ready), 32'd1);
        issue(2'b00, 32'h0, 32'h15, 32'h0);
        chk("w_strobe",    32'(avm_write), 32'd1);
        chk("w_no_read",   32'(avm_read), 32'd0);
        chk("w_addr",      avm_address, 32'h0);
        chk("w_wdata",     avm_writedata, 32'h15);
        chk("w_be",        32'(avm_be), 32'hF);
        chk("w_ready_lo",  32'(cmd_ready), 32'd0);
        chk("w_rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        chk("w_strobe_off", 32'(avm_write), 32'd0);
        chk("w_rsp_valid",  32'(rsp_valid), 32'd1);
        chk("w_rsp_stat",   32'(rsp_status), 32'd0);
        chk("w_rsp_data",   rsp_data, 32'd0);
        chk("w_count",      32'(writes_seen - w0), 32'd1);
        tick();
        chk("w_rsp_done",   32'(rsp_valid), 32'd0);
        chk("w_ready_back", 32'(cmd_ready), 32'd1);

        // READ with 3 waitrequest cycles
        waitreq = 1'b1;
        issue(2'b01, 32'h4, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("r_hold_read", 32'(avm_read), 32'd1);
            chk("r_hold_addr", avm_address, 32'h4);
            tick();
        end
        waitreq = 1'b0;
        chk("r_last_read", 32'(avm_read), 32'd1);
        tick();
        chk("r_read_off", 32'(avm_read), 32'd0);
        rdv   = 1'b1;
        rdata = 32'h3FFF_FFFF;
        tick();
        rdv = 1'b0;
        chk("r_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r_rsp_data",  rsp_data, 32'h3FFF_FFFF);
        chk("r_rsp_stat",  32'(rsp_status), 32'd0);
        tick();

        // POLL mask 1 value 1, slave returns 0, 0, 1
        r0 = reads_seen;
        issue(2'b10, 32'h8, 32'h1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("p_read_issue", 32'(avm_read), 32'd1);
            tick();
            rdv   = 1'b1;
            rdata = (i == 2) ? 32'h1 : 32'h0;
            chk("p_read_wait", 32'(avm_read), 32'd0);
            tick();
            rdv = 1'b0;
        end
        chk("p_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("p_rsp_data",  rsp_data, 32'h1);
        chk("p_rsp_stat",  32'(rsp_status), 32'd0);
        chk("p_reads",     32'(reads_seen - r0), 32'd3);
        tick();

        // READ with data arriving on the watchdog's final cycle
        issue(2'b01, 32'hC, 32'h0, 32'h0);
        tick();
        repeat (14) tick();
        chk("dw_no_rsp", 32'(rsp_valid), 32'd0);
        rdv   = 1'b1;
        rdata = 32'h5A5A_5A5A;
        tick();
        rdv = 1'b0;
        chk("dw_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("dw_rsp_stat",  32'(rsp_status), 32'd0);
        chk("dw_rsp_data",  rsp_data, 32'h5A5A_5A5A);
        tick();

        // Stray readdatavalid in IDLE, then reserved op
        rdv   = 1'b1;
        rdata = 32'hDEAD_BEEF;
        tick();
        rdv = 1'b0;
        chk("stray_no_rsp", 32'(rsp_valid), 32'd0);
        chk("stray_ready",  32'(cmd_ready), 32'd1);
        issue(2'b11, 32'h20, 32'h77, 32'h0);
        chk("bad_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("bad_rsp_stat",  32'(rsp_status), 32'd2);
        chk("bad_rsp_data",  rsp_data, 32'd0);
        chk("bad_no_read",   32'(avm_read), 32'd0);
        chk("bad_no_write",  32'(avm_write), 32'd0);
        tick();

        // POLL never matching: gives up after 3 reads; response held while rsp_ready low
        rsp_ready = 1'b0;
        r0 = reads_seen;
        issue(2'b10, 32'h10, 32'hAA, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            chk("pt_read_issue", 32'(avm_read), 32'd1);
            tick();
            rdv   = 1'b1;
            rdata = 32'h11 * 32'(i + 1);
            tick();
            rdv = 1'b0;
        end
        chk("pt_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("pt_rsp_stat",  32'(rsp_status), 32'd1);
        chk("pt_rsp_data",  rsp_data, 32'h33);
        chk("pt_reads",     32'(reads_seen - r0), 32'd3);
        tick();
        chk("pt_hold_valid", 32'(rsp_valid), 32'd1);
        chk("pt_hold_data",  rsp_data, 32'h33);
        chk("pt_no_4th",     32'(avm_read), 32'd0);
        chk("pt_ready_lo",   32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        chk("pt_rsp_done", 32'(rsp_valid), 32'd0);
        do_reset();
        tick();

        // READ with no readdatavalid: timeout after 15 WAIT_DATA cycles
        issue(2'b01, 32'h14, 32'h0, 32'h0);
        chk("to_read_issue", 32'(avm_read), 32'd1);
        tick();
        for (int k = 0; k < 15; k++) begin
            chk("to_read_low", 32'(avm_read), 32'd0);
            chk("to_no_rsp",   32'(rsp_valid), 32'd0);
            tick();
        end
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_stat",  32'(rsp_status), 32'd1);
        chk("to_rsp_data",  rsp_data, 32'd0);
        tick();
        do_reset();
        tick();

        // Asynchronous reset while avm_read is high
        waitreq = 1'b1;
        issue(2'b01, 32'h18, 32'h0, 32'h0);
        chk("ar_read_hi", 32'(avm_read), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_read_lo",  32'(avm_read), 32'd0);
        chk("ar_no_rsp",   32'(rsp_valid), 32'd0);
        chk("ar_ready",    32'(cmd_ready), 32'd1);
        tick();
        reset_n = 1'b1;
        waitreq = 1'b0;
        tick();
        chk("ar_after_rsp",   32'(rsp_valid), 32'd0);
        chk("ar_after_ready", 32'(cmd_ready), 32'd1);
        chk("ar_after_read",  32'(avm_read), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
